// File: rtl/spi_slave.sv
// spi_slave: mode-0 (CPOL=0, CPHA=0), MSB-first, 8-bit SPI responder with a
// four-register CPU window (TX, RX, STATUS, CONTROL).
//
// Optional build macro: SPI_SLAVE_OVERRUN_EN
//   defined   - a byte completing while rx_full=1 is dropped and sets overrun
//               (STATUS bit3, cleared by CONTROL bit0).
//   undefined - a byte completing while rx_full=1 overwrites rx_buffer; no
//               overrun register exists and STATUS bit3 reads 0.
//
// CPU handshake: a single-cycle access is taken on every raw_clk edge where
// enable=1; write_enable=1 selects a write, otherwise a read. Reads return
// their data on data_out one cycle later; data_out holds between reads.
//
// fsm_state exposes the SPI FSM: 0=WAIT_IDLE, 1=IDLE, 2=ACTIVE.
`timescale 1ns/1ps

module spi_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'hff
) (
  input  logic        raw_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        write_enable,
  input  logic [1:0]  address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        rx_ready,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  // Synchroniser chains; the last stage is the usable, synchronised value.
  logic [SYNC_STAGES-1:0] sclk_sr;
  logic [SYNC_STAGES-1:0] cs_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   sclk_d;
  logic                   cs_d;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  // SPI-side state
  state_t     state;
  logic [7:0] shift_tx;
  logic [7:0] shift_rx;
  logic [2:0] bit_cnt;
  logic       reload;
  logic       miso;
  logic       miso_oe;

  // CPU-side registers
  logic [7:0] tx_buffer;
  logic       tx_valid;
  logic [7:0] rx_buffer;
  logic       rx_full;
  logic       en;
  logic       overrun;

  // Combinational helpers
  logic [7:0] tx_next;
  logic [7:0] rx_byte;
  logic       start;
  logic       reload_now;
  logic       tx_take;
  logic       byte_done;
  logic       cpu_wr;
  logic       cpu_rd;
  logic       rx_rd;
  logic       unused_data;

  assign sclk_s = sclk_sr[SYNC_STAGES-1];
  assign cs_s   = cs_sr[SYNC_STAGES-1];
  assign mosi_s = mosi_sr[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  assign spi_miso    = miso;
  assign spi_miso_oe = miso_oe;
  assign rx_ready    = rx_full;
  assign fsm_state   = state;

  // Upper CPU data bits are never used by this block.
  assign unused_data = ^data_in[15:8];

  // Synchronise the SPI pins; cs_n starts as "selected" so that WAIT_IDLE
  // only leaves once a genuine deselect has been observed after reset.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      sclk_sr <= '0;
      cs_sr   <= '0;
      mosi_sr <= '0;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], spi_sclk};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
      sclk_d  <= sclk_s;
      cs_d    <= cs_s;
    end
  end

  // Decode load points, byte completion and CPU access types.
  always_comb begin
    tx_next    = tx_valid ? tx_buffer : FILL_BYTE;
    rx_byte    = {shift_rx[6:0], mosi_s};
    start      = (state == IDLE) && cs_fall && en;
    reload_now = (state == ACTIVE) && !cs_rise && sclk_fall && reload;
    tx_take    = start || reload_now;
    byte_done  = (state == ACTIVE) && !cs_rise && sclk_rise && (bit_cnt == 3'd7);
    cpu_wr     = enable && write_enable;
    cpu_rd     = enable && !write_enable;
    rx_rd      = cpu_rd && (address == 2'd1);
  end

  // SPI framing FSM: shifts mosi in on sclk rise, miso out on sclk fall.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state    <= WAIT_IDLE;
      shift_tx <= 8'h00;
      shift_rx <= 8'h00;
      bit_cnt  <= 3'd0;
      reload   <= 1'b0;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
    end else begin
      case (state)
        WAIT_IDLE: begin
          miso    <= 1'b0;
          miso_oe <= 1'b0;
          if (cs_s) state <= IDLE;
        end
        IDLE: begin
          miso    <= 1'b0;
          miso_oe <= 1'b0;
          if (start) begin
            state    <= ACTIVE;
            shift_tx <= tx_next;
            bit_cnt  <= 3'd0;
            reload   <= 1'b0;
            miso     <= tx_next[7];
            miso_oe  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            // Partial byte is simply abandoned; shift_rx is restarted by
            // bit_cnt on the next frame.
            state   <= en ? IDLE : WAIT_IDLE;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            reload  <= 1'b0;
          end else if (sclk_rise) begin
            shift_rx <= rx_byte;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) reload <= 1'b1;
          end else if (sclk_fall) begin
            if (reload) begin
              shift_tx <= tx_next;
              miso     <= tx_next[7];
              reload   <= 1'b0;
            end else begin
              shift_tx <= {shift_tx[6:0], 1'b0};
              miso     <= shift_tx[6];
            end
          end
        end
        default: begin
          state   <= WAIT_IDLE;
          miso    <= 1'b0;
          miso_oe <= 1'b0;
        end
      endcase
    end
  end

  // CPU register window and RX/TX buffer bookkeeping.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      data_out  <= 16'h0000;
      tx_buffer <= FILL_BYTE;
      tx_valid  <= 1'b0;
      rx_buffer <= 8'h00;
      rx_full   <= 1'b0;
      en        <= 1'b0;
    end else begin
      // A load consumes the queued byte; a same-cycle TX write below wins
      // and re-arms tx_valid for the following byte.
      if (tx_take) tx_valid <= 1'b0;

      if (cpu_wr) begin
        case (address)
          2'd0: begin
            tx_buffer <= data_in[7:0];
            tx_valid  <= 1'b1;
          end
          2'd3: begin
            en <= data_in[1];
            if (data_in[2]) tx_valid <= 1'b0;
          end
          default: ;
        endcase
      end

      if (cpu_rd) begin
        case (address)
          2'd0: data_out <= {8'h00, tx_buffer};
          2'd1: begin
            data_out <= {8'h00, rx_buffer};
            rx_full  <= 1'b0;
          end
          2'd2: data_out <= {12'h000, overrun, tx_valid, rx_full, ~cs_s};
          default: data_out <= {14'h0000, en, 1'b0};
        endcase
      end

      // Completion after the read clear: a coinciding RX read frees the
      // buffer, so the new byte lands and rx_full stays set.
      if (byte_done) begin
        if (!rx_full || rx_rd) begin
          rx_buffer <= rx_byte;
          rx_full   <= 1'b1;
        end else begin
`ifndef SPI_SLAVE_OVERRUN_EN
          rx_buffer <= rx_byte;
`endif
        end
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  // Sticky overrun: set when an unread byte would be overwritten.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (byte_done && rx_full && !rx_rd) begin
      overrun <= 1'b1;
    end else if (cpu_wr && (address == 2'd3) && data_in[0]) begin
      overrun <= 1'b0;
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed SPI master transactions, a transaction-level
// model of the register window and the byte stream, and a per-cycle compare
// of the steady-state outputs.
`timescale 1ns/1ps

module tb_spi_slave;

  localparam logic [7:0] FILL = 8'hff;

  // Clock / reset
  logic        raw_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        write_enable;
  logic [1:0]  address;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        rx_ready;
  logic [1:0]  fsm_state;

  always #5 raw_clk = ~raw_clk;

  spi_slave dut (
    .raw_clk      (raw_clk),
    .reset        (reset),
    .enable       (enable),
    .write_enable (write_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .rx_ready     (rx_ready),
    .fsm_state    (fsm_state)
  );

  // Scoreboard counters and model state
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_tx_buf;
  logic       m_tx_valid;
  logic [7:0] m_rx;
  logic       m_rx_full;
  logic       m_ov;
  logic       m_en;
  logic       m_wait_idle;
  logic       m_active;
  bit         settled = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte the slave must shift out next: queued TX byte or the fill byte.
  task automatic model_reload();
    exp_q.push_back(m_tx_valid ? m_tx_buf : FILL);
    m_tx_valid = 1'b0;
  endtask

  // Steady-state compare, sampled away from the active edge.
  initial begin
    forever begin
      @(posedge raw_clk);
      #2;
      if (settled) begin
        chk("rx_ready", 16'(rx_ready), 16'(m_rx_full));
        chk("miso_oe", 16'(spi_miso_oe), 16'(m_active));
        if (!m_active) chk("miso_idle", 16'(spi_miso), 16'h0000);
        chk("fsm_state", 16'(fsm_state),
            m_wait_idle ? 16'd0 : (m_active ? 16'd2 : 16'd1));
      end
    end
  end

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: all start and end just after a falling raw_clk edge.
  task automatic do_reset();
    settled = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge raw_clk);
    chk("reset_data_out", data_out, 16'h0000);
    chk("reset_miso", 16'(spi_miso), 16'h0000);
    chk("reset_miso_oe", 16'(spi_miso_oe), 16'h0000);
    chk("reset_rx_ready", 16'(rx_ready), 16'h0000);
    reset = 1'b0;
    m_tx_buf = FILL; m_tx_valid = 1'b0; m_rx = 8'h00; m_rx_full = 1'b0;
    m_ov = 1'b0; m_en = 1'b0; m_active = 1'b0; m_wait_idle = spi_cs_n ? 1'b0 : 1'b1;
    exp_q.delete();
    repeat (4) @(negedge raw_clk);
    settled = 1'b1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [15:0] d);
    enable = 1'b1; write_enable = 1'b1; address = a; data_in = d;
    if (a == 2'd0) begin
      m_tx_buf = d[7:0];
      m_tx_valid = 1'b1;
    end else if (a == 2'd3) begin
`ifdef SPI_SLAVE_OVERRUN_EN
      if (d[0]) m_ov = 1'b0;
`endif
      m_en = d[1];
      if (d[2]) m_tx_valid = 1'b0;
    end
    @(negedge raw_clk);
    enable = 1'b0; write_enable = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [15:0] d);
    logic [15:0] e;
    case (a)
      2'd0:    e = {8'h00, m_tx_buf};
      2'd1:    e = {8'h00, m_rx};
      2'd2:    e = {12'h000, m_ov, m_tx_valid, m_rx_full, ~spi_cs_n};
      default: e = {14'h0000, m_en, 1'b0};
    endcase
    enable = 1'b1; write_enable = 1'b0; address = a;
    if (a == 2'd1) m_rx_full = 1'b0;
    @(negedge raw_clk);
    d = data_out;
    enable = 1'b0;
    chk($sformatf("model_read_addr%0d", a), d, e);
  endtask

  task automatic cs_set(input logic v);
    settled = 1'b0;
    spi_cs_n = v;
    if (!v) begin
      if (!m_wait_idle && m_en && !m_active) begin
        m_active = 1'b1;
        exp_q.delete();
        model_reload();
      end
    end else begin
      if (m_active) begin
        m_active = 1'b0;
        if (!m_en) m_wait_idle = 1'b1;
      end
      m_wait_idle = 1'b0;
      exp_q.delete();
    end
    repeat (8) @(negedge raw_clk);
    settled = 1'b1;
  endtask

  // SPI master: nbits mode-0 clocks at raw_clk/8. Optionally writes TX
  // during bit wr_bit, or issues an RX read on the cycle the byte completes.
  task automatic xfer(input logic [7:0] mo, input int nbits, input int wr_bit,
                      input logic [7:0] wr_val, input bit rd_done,
                      output logic [7:0] got, output logic [15:0] rd_val);
    logic [7:0] e;
    logic [7:0] rd_exp;
    bit         counted;
    counted = m_active && (nbits == 8);
    got = 8'h00;
    rd_val = 16'h0000;
    rd_exp = m_rx;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      if (i == wr_bit) begin
        cpu_write(2'd0, {8'h00, wr_val});
        repeat (3) @(negedge raw_clk);
      end else begin
        repeat (4) @(negedge raw_clk);
      end
      got = {got[6:0], spi_miso};
      if (i == 7) settled = 1'b0;
      spi_sclk = 1'b1;
      if (rd_done && i == 7) begin
        repeat (2) @(negedge raw_clk);
        enable = 1'b1; write_enable = 1'b0; address = 2'd1;
        @(negedge raw_clk);
        rd_val = data_out;
        enable = 1'b0;
        @(negedge raw_clk);
      end else begin
        repeat (4) @(negedge raw_clk);
      end
      spi_sclk = 1'b0;
    end
    if (counted) begin
      if (exp_q.size() == 0) begin
        chk("miso_byte_missing", 16'(got), 16'h0100);
      end else begin
        e = exp_q.pop_front();
        chk("miso_byte", 16'(got), 16'(e));
      end
      if (!m_rx_full || rd_done) begin
        m_rx = mo;
        m_rx_full = 1'b1;
      end else begin
`ifdef SPI_SLAVE_OVERRUN_EN
        m_ov = 1'b1;
`else
        m_rx = mo;
`endif
      end
      if (rd_done) chk("rx_read_at_done_model", rd_val, {8'h00, rd_exp});
      model_reload();
    end
    repeat (4) @(negedge raw_clk);
    settled = 1'b1;
  endtask

  // Directed test sequence
  initial begin
    logic [7:0]  got;
    logic [15:0] rv;
    logic [15:0] rd;
    reset = 1'b1; enable = 1'b0; write_enable = 1'b0; address = 2'd0;
    data_in = 16'h0000; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    @(negedge raw_clk);
    do_reset();

    // 1: basic single-byte exchange
    cpu_write(2'd3, 16'h0002);
    cpu_write(2'd0, 16'h00A5);
    cs_set(1'b0);
    xfer(8'h3C, 8, -1, 8'h00, 1'b0, got, rd);
    chk("t1_miso", 16'(got), 16'h00A5);
    cpu_read(2'd2, rv); chk("t1_status_low", rv, 16'h0003);
    cs_set(1'b1);
    cpu_read(2'd1, rv); chk("t1_rx", rv, 16'h003C);
    cpu_read(2'd2, rv); chk("t1_status_after", rv, 16'h0000);
    cpu_read(2'd3, rv); chk("t1_control", rv, 16'h0002);

    // 2: two-byte frame, underrun on byte 2, second byte hits a full buffer
    cpu_write(2'd0, 16'h0012);
    cs_set(1'b0);
    xfer(8'hF0, 8, -1, 8'h00, 1'b0, got, rd); chk("t2_miso0", 16'(got), 16'h0012);
    xfer(8'h0F, 8, -1, 8'h00, 1'b0, got, rd); chk("t2_miso1", 16'(got), 16'h00FF);
    cs_set(1'b1);
`ifdef SPI_SLAVE_OVERRUN_EN
    cpu_read(2'd2, rv); chk("t2_status_ov", rv, 16'h000A);
    cpu_read(2'd1, rv); chk("t2_rx_kept", rv, 16'h00F0);
    cpu_write(2'd3, 16'h0003);
    cpu_read(2'd2, rv); chk("t2_ov_cleared", rv, 16'h0000);
`else
    cpu_read(2'd2, rv); chk("t2_status", rv, 16'h0002);
    cpu_read(2'd1, rv); chk("t2_rx_overwritten", rv, 16'h000F);
    cpu_write(2'd3, 16'h0003);
`endif

    // 3: aborted partial byte, then a clean frame
    cs_set(1'b0);
    xfer(8'hAA, 5, -1, 8'h00, 1'b0, got, rd);
    cs_set(1'b1);
    cpu_read(2'd2, rv); chk("t3_status_empty", rv, 16'h0000);
`ifdef SPI_SLAVE_OVERRUN_EN
    cpu_read(2'd1, rv); chk("t3_rx_unchanged", rv, 16'h00F0);
`else
    cpu_read(2'd1, rv); chk("t3_rx_unchanged", rv, 16'h000F);
`endif
    cs_set(1'b0);
    xfer(8'h55, 8, -1, 8'h00, 1'b0, got, rd); chk("t3_miso_fill", 16'(got), 16'h00FF);
    cs_set(1'b1);
    cpu_read(2'd1, rv); chk("t3_rx", rv, 16'h0055);

    // 5: TX write mid-byte only affects the following byte
    cpu_write(2'd0, 16'h00C3);
    cs_set(1'b0);
    xfer(8'h01, 8, 3, 8'h77, 1'b0, got, rd); chk("t5_miso_cur", 16'(got), 16'h00C3);
    xfer(8'h02, 8, -1, 8'h00, 1'b0, got, rd); chk("t5_miso_next", 16'(got), 16'h0077);
    cs_set(1'b1);
    cpu_read(2'd2, rv);
    cpu_read(2'd1, rv);
    cpu_write(2'd3, 16'h0003);

    // 6: RX read on the completion cycle
    cs_set(1'b0);
    xfer(8'h11, 8, -1, 8'h00, 1'b0, got, rd);
    xfer(8'h9E, 8, -1, 8'h00, 1'b1, got, rd);
    chk("t6_read_old", rd, 16'h0011);
    cpu_read(2'd2, rv); chk("t6_status", rv, 16'h0003);
    cs_set(1'b1);
    cpu_read(2'd1, rv); chk("t6_rx_new", rv, 16'h009E);

    // 4: reset mid-byte with cs_n held low
    cs_set(1'b0);
    xfer(8'hAA, 3, -1, 8'h00, 1'b0, got, rd);
    do_reset();
    chk("t4_wait_idle", 16'(fsm_state), 16'h0000);
    cpu_write(2'd3, 16'h0002);
    xfer(8'hAA, 5, -1, 8'h00, 1'b0, got, rd);
    chk("t4_oe_off", 16'(spi_miso_oe), 16'h0000);
    cpu_read(2'd2, rv); chk("t4_no_capture", rv, 16'h0001);
    cs_set(1'b1);
    cs_set(1'b0);
    xfer(8'h5A, 8, -1, 8'h00, 1'b0, got, rd); chk("t4_miso", 16'(got), 16'h00FF);
    cs_set(1'b1);
    cpu_read(2'd1, rv); chk("t4_rx", rv, 16'h005A);

    repeat (4) @(negedge raw_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI responder peripheral: an external master drives sclk/cs_n/mosi, and this block returns bytes on miso.
- It is the target-side counterpart of the on-chip SPI initiator. It lets the F100-L act as a slave device to an external MCU.
- It sits in the peripherals address space next to the SPI initiator and IO ports.
- CPU access is through a small register window: TX data, RX data, status and control.
- The protocol is mode 0 (CPOL=0, CPHA=0), MSB-first, 8-bit frames.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each of sclk, cs_n and mosi; minimum 2.
- FILL_BYTE, 8'hff: byte shifted out on miso when no TX byte is queued (underrun).

Ports:
- raw_clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- enable  input  1  CPU access strobe for this block.
- write_enable  input  1  CPU write qualifier.
- address  input  2  register select: 0=TX, 1=RX, 2=STATUS, 3=CONTROL.
- data_in  input  16  CPU write data; only [7:0] used.
- data_out  output  16  CPU read data, registered.
- spi_sclk  input  1  external SPI clock, asynchronous.
- spi_cs_n  input  1  external chip select, active-low, asynchronous.
- spi_mosi  input  1  external serial data in.
- spi_miso  output  1  serial data out.
- spi_miso_oe  output  1  miso output enable, for the top-level tristate.
- rx_ready  output  1  mirrors status rx_full; for polling or an interrupt line.

Behaviour:
Reset:
- data_out=0, spi_miso=0, spi_miso_oe=0, rx_ready=0.
- tx_buffer=FILL_BYTE, tx_valid=0, rx_buffer=0, rx_full=0, overrun=0, en=0.
- FSM goes to WAIT_IDLE.

Synchronisers and edge detection:
- sclk, cs_n and mosi pass through SYNC_STAGES flops.
- Edges are detected on the synced signals against a one-cycle-delayed copy.
- Supported sclk is at most raw_clk/8.

FSM:
- WAIT_IDLE: stay until synced cs_n=1, then go to IDLE. This prevents a partial frame after reset or after en is set while cs_n is low.
- IDLE: miso_oe=0, miso=0. On a cs_n falling edge with en=1, go to ACTIVE:
  - shift_tx <= tx_valid ? tx_buffer : FILL_BYTE; tx_valid <= 0; bit_cnt <= 0.
  - miso is driven from shift_tx[7] on the next cycle; miso_oe=1.
- ACTIVE, sclk rising: shift_rx <= {shift_rx[6:0], mosi_sync}; bit_cnt++. When bit_cnt was 7, the byte completes:
  - If rx_full=0: rx_buffer <= assembled byte; rx_full <= 1.
  - If rx_full=1: overrun handling (see Optional Feature).
  - bit_cnt <= 0 and the reload flag is set.
- ACTIVE, sclk falling:
  - If the reload flag is set: shift_tx <= tx_valid ? tx_buffer : FILL_BYTE; tx_valid <= 0; clear the flag.
  - Otherwise shift_tx <= shift_tx << 1.
  - miso follows shift_tx[7].
- ACTIVE, cs_n rising (any bit_cnt): discard the partial byte, leave rx_buffer unchanged, go to IDLE. miso_oe=0 on the next cycle.
- en cleared while ACTIVE: finish to cs_n rising as above, then go to WAIT_IDLE.

CPU interface (registered, 1-cycle read latency):
- Write addr0: tx_buffer <= data_in[7:0]; tx_valid <= 1. The new value is used at the next byte boundary, never mid-byte.
- Write addr3:
  - bit0=1 clears overrun.
  - bit1 sets en.
  - bit2=1 flushes tx_valid.
- Read addr0: returns {8'b0, tx_buffer}.
- Read addr1: returns {8'b0, rx_buffer}; rx_full <= 0.
- Read addr2: returns {12'b0, overrun, tx_valid, rx_full, ~cs_n_sync}.
- Read addr3: returns {14'b0, en, 1'b0}.
- data_out holds its value when enable=0.

Simultaneous events:
- RX read in the same cycle as byte completion: data_out gets the old rx_buffer; the new byte is written and rx_full stays 1. Overrun is not flagged.
- TX write in the same cycle as a reload: the reload uses the old state; the new byte sets tx_valid for the following byte.
- reset has priority over everything.

Optional Feature:
Macro SPI_SLAVE_OVERRUN_EN.
- Defined: a byte completing while rx_full=1 sets overrun=1 and is discarded; rx_buffer keeps the unread byte. Status bit3 reports overrun; it clears via CONTROL bit0.
- Undefined: the completing byte overwrites rx_buffer and rx_full stays 1. Status bit3 reads 0 and CONTROL bit0 is ignored; the overrun register is not built.

Test Plan:
1. Reset, then write CONTROL=2 and TX=8'hA5. Master sends 8'h3C with cs_n low, sclk=raw_clk/8 → master reads 8'hA5 on miso; status=0x3 while cs_n is still low; after cs_n high, RX read returns 0x003C and the next status read returns 0x0000.
2. Two-byte frame with TX=8'h12 queued only before the frame, master sends 8'hF0 then 8'h0F → miso gives 8'h12 then 8'hFF (underrun); rx_buffer holds 8'hF0.
   - SPI_SLAVE_OVERRUN_EN defined: overrun=1 and rx_buffer stays 8'hF0.
   - Undefined: rx_buffer=8'h0F.
3. cs_n deasserted after 5 sclk rising edges of byte 8'hAA → rx_full stays 0, rx_buffer unchanged. The next full frame of 8'h55 is received correctly.
4. Reset asserted mid-byte while cs_n stays low → FSM stays in WAIT_IDLE and miso_oe=0 through the remaining sclks; no byte is captured. After cs_n high and low again, the next frame is received normally.
5. TX write of 8'h77 during bit 3 of an active byte whose shift data is 8'hC3 → the current byte is still 8'hC3 on miso, and the next byte is 8'h77.
6. RX read issued on the exact cycle a byte 8'h9E completes, with the previous byte 8'h11 unread → data_out=0x0011, rx_full=1, overrun=0; the next RX read returns 0x009E.
